fir_tap_scheduler: RTL



---
 rtl/fir_ctrl_pkg.sv | 35 +++
 rtl/tap_counter.sv | 44 ++++
 rtl/fir_tap_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared definitions for the FIR control path: sequencer state encoding,
// default tap depth / MAC latency and the tap-address width helper.
// The sample-fetch, MAC and scheduler blocks all import this package so
// they agree on depth and latency.
package fir_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } ctrlState_t;

  // Default datapath shape shared across the FIR blocks
  localparam int DEF_S_DEPTH   = 29;
  localparam int DEF_MAC_LAT   = 2;
  localparam int DEF_CNT_WIDTH = 16;

  // Tap-address width; kept at least one bit so a single-tap build still
  // has a legal select port.
  function automatic int tapWidth(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/tap_counter.sv
// tap_counter
// Loadable up-counter with a terminal-count flag.
// Ports:
//   clk      in   clock, all updates on posedge
//   reset    in   synchronous active-low reset, clears the count
//   load     in   load loadVal (has priority over inc)
//   loadVal  in   WIDTH value loaded when load is high
//   inc      in   advance the count by one
//   count    out  WIDTH current count (registered)
//   tc       out  high while count equals MAX_VAL
module tap_counter #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] countR;

  // Count register: load wins over increment, otherwise hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      countR <= '0;
    end else if (load) begin
      countR <= loadVal;
    end else if (inc) begin
      countR <= countR + WIDTH'(1);
    end else begin
      countR <= countR;
    end
  end

  assign count = countR;
  assign tc    = (countR == MAX_L);

endmodule

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler
// Control sequencer for the time-multiplexed FIR datapath. Per sample:
// SHIFT (pull one I/Q sample into the tap registers), RUN (walk the shared
// MAC across every tap), DRAIN (wait out the MAC pipeline), HOLD (present
// the result with a valid/ready handshake).
// Ports:
//   clk        in   sole clock
//   reset      in   synchronous active-low reset
//   enable     in   permits a new sample to start (looked at in IDLE only)
//   empty      in   registered empty flag from sample fetch
//   can_shift  out  one-cycle pulse moving the FIFO head into the taps
//   tap_idx    out  tap-mux select / coefficient ROM address
//   mac_clear  out  load instead of accumulate (tap 0 only)
//   mac_en     out  MAC issue strobe
//   out_valid  out  accumulator result valid
//   out_ready  in   downstream accepts the result
//   busy       out  high in every state except IDLE
//   frame_cnt  out  completed handshakes, wrapping
// All outputs are registered.
module fir_tap_scheduler
  import fir_ctrl_pkg::*;
#(
  parameter int S_DEPTH   = DEF_S_DEPTH,
  parameter int MAC_LAT   = DEF_MAC_LAT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          empty,
  output logic                          can_shift,
  output logic [tapWidth(S_DEPTH)-1:0]  tap_idx,
  output logic                          mac_clear,
  output logic                          mac_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          frame_cnt
);

  localparam int TAP_W     = tapWidth(S_DEPTH);
  localparam int DRAIN_W   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int DRAIN_MAX = (MAC_LAT > 0) ? (MAC_LAT - 1) : 0;
  localparam bit SKIP_DRAIN = (MAC_LAT == 0);

  ctrlState_t stateR;
  ctrlState_t nextStateS;

  logic                 canShiftR;
  logic                 macClearR;
  logic                 macEnR;
  logic                 outValidR;
  logic                 busyR;
  logic [CNT_WIDTH-1:0] frameCntR;

  logic [TAP_W-1:0]   tapCntS;
  logic               tapTcS;
  logic               tapLoadS;
  logic               drainTcS;
  logic               drainLoadS;
  // The drain phase only needs the terminal flag, not the count itself.
  logic [DRAIN_W-1:0] unusedDrainCnt;
  logic               handshakeS;

  // Counters sit at 0 outside their phase and advance only inside it; the
  // terminal cycle reloads 0 so tap_idx is already 0 on the exit cycle.
  assign tapLoadS   = !((stateR == RUN) && !tapTcS);
  assign drainLoadS = !((stateR == DRAIN) && !drainTcS);
  assign handshakeS = outValidR && out_ready;

  tap_counter #(
    .WIDTH   (TAP_W),
    .MAX_VAL (S_DEPTH - 1)
  ) uTapCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (tapLoadS),
    .loadVal ({TAP_W{1'b0}}),
    .inc     (stateR == RUN),
    .count   (tapCntS),
    .tc      (tapTcS)
  );

  tap_counter #(
    .WIDTH   (DRAIN_W),
    .MAX_VAL (DRAIN_MAX)
  ) uDrainCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (drainLoadS),
    .loadVal ({DRAIN_W{1'b0}}),
    .inc     (stateR == DRAIN),
    .count   (unusedDrainCnt),
    .tc      (drainTcS)
  );

  // Next-state decode
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (enable && !empty) begin
          nextStateS = SHIFT;
        end else begin
          nextStateS = IDLE;
        end
      end
      SHIFT: begin
        nextStateS = RUN;
      end
      RUN: begin
        if (tapTcS && SKIP_DRAIN) begin
          nextStateS = HOLD;
        end else if (tapTcS) begin
          nextStateS = DRAIN;
        end else begin
          nextStateS = RUN;
        end
      end
      DRAIN: begin
        if (drainTcS) begin
          nextStateS = HOLD;
        end else begin
          nextStateS = DRAIN;
        end
      end
      HOLD: begin
        if (handshakeS) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = HOLD;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // State register and outputs decoded from the next state, so every
  // strobe lines up with the state it belongs to. mac_clear is set on the
  // SHIFT->RUN edge, which is exactly when tap 0 is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateR    <= IDLE;
      canShiftR <= 1'b0;
      macClearR <= 1'b0;
      macEnR    <= 1'b0;
      outValidR <= 1'b0;
      busyR     <= 1'b0;
      frameCntR <= '0;
    end else begin
      stateR    <= nextStateS;
      canShiftR <= (nextStateS == SHIFT);
      macClearR <= (stateR == SHIFT);
      macEnR    <= (nextStateS == RUN);
      outValidR <= (nextStateS == HOLD);
      busyR     <= (nextStateS != IDLE);
      if (handshakeS) begin
        frameCntR <= frameCntR + CNT_WIDTH'(1);
      end else begin
        frameCntR <= frameCntR;
      end
    end
  end

  assign can_shift = canShiftR;
  assign tap_idx   = tapCntS;
  assign mac_clear = macClearR;
  assign mac_en    = macEnR;
  assign out_valid = outValidR;
  assign busy      = busyR;
  assign frame_cnt = frameCntR;

endmodule
